nco_capture_writer: RTL and testbench
=====================================

Name: nco_capture_writer

Overview:
- Avalon-MM write master for the on-chip memory second port, the s2 slave that the host reads over PCIe.
- Captures the NCO output stream (36-bit samples with a valid strobe) into memory as 64-bit words.
- Capture can start immediately or wait for a trigger edge, and supports decimation.
- Sits beside the NCO in the same 64-bit clock domain as the s2 port; control comes from host-side registers.

Parameters:
- ADDR_W, 14, memory word-address width (s2 address)
- DATA_W, 64, memory data width; fixed at 64
- SAMPLE_W, 36, NCO sample width
- LEN_W, 15, capture length width; max length 2^ADDR_W words
- DECIM_W, 8, decimation field width

Ports:
- clk_clk  in  1  system clock; all logic on rising edge
- reset_reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches cfg_* and begins a capture
- abort  in  1  cancels the capture in progress
- cfg_base  in  ADDR_W  first word address
- cfg_len  in  LEN_W  number of words to write
- cfg_decim  in  DECIM_W  write every (cfg_decim+1)-th valid sample
- cfg_trig_en  in  1  1 = wait for trig rising edge; 0 = start immediately
- trig  in  1  trigger level input, synchronous to clk_clk
- nco_data  in  SAMPLE_W  NCO sample
- nco_valid  in  1  sample qualifier
- mem_address  out  ADDR_W  s2 address
- mem_chipselect  out  1  s2 chipselect
- mem_clken  out  1  s2 clock enable
- mem_write  out  1  s2 write
- mem_writedata  out  DATA_W  s2 write data
- mem_byteenable  out  8  s2 byte enables
- busy  out  1  high in ARMED or CAPTURE
- done  out  1  sticky completion flag
- words_written  out  LEN_W  writes issued in the current or last capture

Behaviour:
- Reset values:
  - All outputs 0, including mem_byteenable = 0 and mem_clken = 0.
  - State = IDLE; trig_q = 0; decimation counter = 0; index = 0.
- States and transitions:
  - IDLE → ARMED on start when cfg_trig_en = 1.
  - IDLE → CAPTURE on start when cfg_trig_en = 0.
  - IDLE → DONE on start when cfg_len = 0; no writes occur.
  - ARMED → CAPTURE on trig = 1 with trig_q = 0 (registered edge detect).
  - CAPTURE → DONE when the write with index = len-1 is issued.
  - DONE behaves as IDLE and accepts start.
- cfg_* values are latched on start; later changes are ignored until the next start.
- start while busy is ignored.
- Any start clears done and words_written.
- Entering CAPTURE clears the decimation counter and index.
- No sample is taken in the cycle of the ARMED → CAPTURE transition.
- Sample accept (CAPTURE, nco_valid = 1):
  - If the counter is 0, the sample is written and the counter loads cfg_decim.
  - Otherwise the counter decrements and no write occurs.
  - Invalid cycles do not change the counter.
- Write timing: an accept in cycle N produces a single-cycle write in cycle N+1 (latency 1):
  - mem_write = mem_chipselect = mem_clken = 1, mem_byteenable = 8'hFF.
  - mem_address = (base + index) mod 2^ADDR_W; the address wraps silently from 16383 to 0.
  - mem_writedata = {13'b0, index[14:0], nco_data[35:0]}.
  - words_written = index + 1, updated in the same cycle N+1.
- Outside write cycles the strobes are 0; address and data hold their last values.
- s2 has no waitrequest; every write completes in one cycle and back-to-back writes are allowed every cycle.
- done:
  - Asserts in the cycle after the final write is on the bus; busy deasserts that same cycle.
  - Stays high until the next start or reset.
- abort:
  - Has priority over sample accept and trigger.
  - The next state is IDLE, and done stays 0.
  - A write already on the bus in the abort cycle completes; no write is issued in the following cycle.
  - words_written holds its value.
- Simultaneous start and abort while idle: abort wins and no capture starts.
- Reset mid-capture: all outputs return to reset values on the next edge, and the write in flight is dropped.

Test Plan:
- Immediate capture: cfg_base = 100, cfg_len = 4, cfg_decim = 0, cfg_trig_en = 0, nco_valid held high with data 0x1, 0x2, … → writes to 100..103 with data {13'b0, 0..3, samples}, one per cycle; done = 1 one cycle after the write to 103; words_written = 4.
- Decimation: cfg_decim = 2, cfg_len = 3, samples 1..9 with nco_valid toggling → only samples 1, 4 and 7 are written; invalid cycles do not advance the counter.
- Trigger: cfg_trig_en = 1, trig low for 10 cycles with samples flowing → no writes and busy = 1; trig rises at cycle T → the first write carries the sample accepted at T+1.
- Wrap and zero length:
  - cfg_base = 16382, cfg_len = 4 → addresses 16382, 16383, 0, 1.
  - cfg_len = 0 → done = 1 the cycle after start, with no mem_write.
- Abort/reset:
  - abort after 2 of 8 writes → exactly 2 writes, busy = 0, done = 0, words_written = 2.
  - start during capture → ignored.
  - reset_reset during capture → all outputs 0 on the next edge.

Source files
------------

// File: rtl/nco_capture_writer_if.sv
// Avalon-MM write-only bus toward the s2 port of the on-chip memory.
// The master drives every signal; the slave (the memory port) only samples.
interface nco_capture_writer_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
);
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect;
  logic                mem_clken;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic [DATA_W/8-1:0] mem_byteenable;

  modport master (
    output mem_address, mem_chipselect, mem_clken, mem_write,
    output mem_writedata, mem_byteenable
  );

  modport slave (
    input mem_address, mem_chipselect, mem_clken, mem_write,
    input mem_writedata, mem_byteenable
  );
endinterface

// File: rtl/nco_capture_writer.sv
// Captures the NCO sample stream, optionally triggered and decimated, into s2 memory words.
// One-cycle accept-to-write latency; s2 never stalls, so a write may issue every cycle.
module nco_capture_writer #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 64,
  parameter int SAMPLE_W = 36,
  parameter int LEN_W    = 15,
  parameter int DECIM_W  = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic [DECIM_W-1:0]  cfg_decim,
  input  logic                cfg_trig_en,
  input  logic                trig,
  input  logic [SAMPLE_W-1:0] nco_data,
  input  logic                nco_valid,
  nco_capture_writer_if.master mem,
  output logic                busy,
  output logic                done,
  output logic [LEN_W-1:0]    words_written
);

  localparam int PAD_W = DATA_W - LEN_W - SAMPLE_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]  base_q;
  logic [LEN_W-1:0]   len_q;
  logic [DECIM_W-1:0] decim_q;
  logic [DECIM_W-1:0] cnt_q;
  logic [LEN_W-1:0]   idx_q;
  logic               trig_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               done_q;
  logic [LEN_W-1:0]   ww_q;

  logic take_start;
  logic enter_cap;
  logic accept;
  logic last_on_bus;

  // idx_q reaches len_q exactly in the cycle the final write sits on the bus.
  assign last_on_bus = (idx_q == len_q);

  always_comb begin
    state_d    = state_q;
    take_start = 1'b0;
    enter_cap  = 1'b0;
    accept     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          take_start = 1'b1;
          if (cfg_len == '0) begin
            state_d = S_DONE;
          end else if (cfg_trig_en) begin
            state_d = S_ARMED;
          end else begin
            state_d   = S_CAPTURE;
            enter_cap = 1'b1;
          end
        end
      end
      S_ARMED: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (trig && !trig_q) begin
          state_d   = S_CAPTURE;
          enter_cap = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_on_bus) begin
          state_d = S_DONE;
        end else begin
          accept = nco_valid;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      decim_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      trig_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      ww_q    <= '0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig;
      wr_q    <= 1'b0;

      if (take_start) begin
        base_q  <= cfg_base;
        len_q   <= cfg_len;
        decim_q <= cfg_decim;
        ww_q    <= '0;
        done_q  <= (cfg_len == '0);
      end

      if (state_q == S_CAPTURE && state_d == S_DONE) begin
        done_q <= 1'b1;
      end

      if (enter_cap) begin
        cnt_q <= '0;
        idx_q <= '0;
      end else if (accept) begin
        if (cnt_q == '0) begin
          cnt_q   <= decim_q;
          idx_q   <= idx_q + 1'b1;
          ww_q    <= idx_q + 1'b1;
          wr_q    <= 1'b1;
          addr_q  <= base_q + idx_q[ADDR_W-1:0];
          wdata_q <= {{PAD_W{1'b0}}, idx_q, nco_data};
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

  // Address and data hold between writes; only the strobes drop.
  assign mem.mem_write      = wr_q;
  assign mem.mem_chipselect = wr_q;
  assign mem.mem_clken      = wr_q;
  assign mem.mem_byteenable = {(DATA_W/8){wr_q}};
  assign mem.mem_address    = addr_q;
  assign mem.mem_writedata  = wdata_q;

  assign busy          = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done          = done_q;
  assign words_written = ww_q;

endmodule

// File: tb/tb_nco_capture_writer.sv
// Directed, table-driven bench for nco_capture_writer plus hand sequences for reset and cfg latching.
module tb_nco_capture_writer;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        start, abort, cfg_trig_en, trig, nco_valid;
  logic [13:0] cfg_base;
  logic [14:0] cfg_len;
  logic [7:0]  cfg_decim;
  logic [35:0] nco_data;
  logic        busy, done;
  logic [14:0] words_written;

  nco_capture_writer_if #(.ADDR_W(14), .DATA_W(64)) mem_bus ();

  nco_capture_writer dut (
    .clk_clk       (clk_clk),
    .reset_reset   (reset_reset),
    .start         (start),
    .abort         (abort),
    .cfg_base      (cfg_base),
    .cfg_len       (cfg_len),
    .cfg_decim     (cfg_decim),
    .cfg_trig_en   (cfg_trig_en),
    .trig          (trig),
    .nco_data      (nco_data),
    .nco_valid     (nco_valid),
    .mem           (mem_bus),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct {
    logic        start, abort, trig, valid;
    logic [35:0] dat;
    logic        ew;
    logic [13:0] ea;
    logic [63:0] ed;
    logic        eb, edn;
    logic [14:0] eww;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic add(input int s, input int a, input int t, input int v, input int d,
                     input int ew, input int ea, input int eidx,
                     input int eb, input int edn, input int eww);
    vec_t r;
    r.start = s[0]; r.abort = a[0]; r.trig = t[0]; r.valid = v[0];
    r.dat   = 36'(d);
    r.ew    = ew[0];
    r.ea    = 14'(ea);
    r.ed    = {13'b0, 15'(eidx), 36'(d)};
    r.eb    = eb[0];
    r.edn   = edn[0];
    r.eww   = 15'(eww);
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_cfg(input int base, input int len, input int decim, input int ten);
    cfg_base    = 14'(base);
    cfg_len     = 15'(len);
    cfg_decim   = 8'(decim);
    cfg_trig_en = ten[0];
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk_clk);
      start     = tbl[i].start;
      abort     = tbl[i].abort;
      trig      = tbl[i].trig;
      nco_valid = tbl[i].valid;
      nco_data  = tbl[i].dat;
      @(posedge clk_clk);
      #1;
      chk($sformatf("row%0d mem_write", i), 64'(mem_bus.mem_write), 64'(tbl[i].ew));
      chk($sformatf("row%0d byteenable", i), 64'(mem_bus.mem_byteenable),
          tbl[i].ew ? 64'hFF : 64'h0);
      chk($sformatf("row%0d busy", i), 64'(busy), 64'(tbl[i].eb));
      chk($sformatf("row%0d done", i), 64'(done), 64'(tbl[i].edn));
      chk($sformatf("row%0d words_written", i), 64'(words_written), 64'(tbl[i].eww));
      if (tbl[i].ew) begin
        chk($sformatf("row%0d address", i), 64'(mem_bus.mem_address), 64'(tbl[i].ea));
        chk($sformatf("row%0d writedata", i), mem_bus.mem_writedata, tbl[i].ed);
      end
    end
    @(negedge clk_clk);
    start = 1'b0; abort = 1'b0; trig = 1'b0; nco_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " mem_write"},      64'(mem_bus.mem_write), 64'h0);
    chk({tag, " chipselect"},     64'(mem_bus.mem_chipselect), 64'h0);
    chk({tag, " clken"},          64'(mem_bus.mem_clken), 64'h0);
    chk({tag, " byteenable"},     64'(mem_bus.mem_byteenable), 64'h0);
    chk({tag, " address"},        64'(mem_bus.mem_address), 64'h0);
    chk({tag, " writedata"},      mem_bus.mem_writedata, 64'h0);
    chk({tag, " busy"},           64'(busy), 64'h0);
    chk({tag, " done"},           64'(done), 64'h0);
    chk({tag, " words_written"},  64'(words_written), 64'h0);
  endtask

  int s_imm, s_dec, s_trg, s_wrp, s_zero, s_abt, s_end;

  initial begin
    reset_reset = 1'b1;
    start = 1'b0; abort = 1'b0; trig = 1'b0; nco_valid = 1'b0; nco_data = '0;
    set_cfg(0, 0, 0, 0);

    // Immediate capture, with a start pulse mid-capture that must be ignored.
    s_imm = tbl.size();
    add(1,0,0,1,0,  0,0,0,   1,0,0);
    add(0,0,0,1,1,  1,100,0, 1,0,1);
    add(1,0,0,1,2,  1,101,1, 1,0,2);
    add(0,0,0,1,3,  1,102,2, 1,0,3);
    add(0,0,0,1,4,  1,103,3, 1,0,4);
    add(0,0,0,1,5,  0,0,0,   0,1,4);
    add(0,0,0,0,0,  0,0,0,   0,1,4);

    // Decimation by 3 with invalid cycles interleaved.
    s_dec = tbl.size();
    add(1,0,0,0,0,  0,0,0, 1,0,0);
    for (int k = 1; k <= 7; k++) begin
      add(0,0,0,1,k, ((k-1)%3 == 0) ? 1 : 0, (k-1)/3, (k-1)/3, 1,0,(k-1)/3+1);
      if (k < 7) add(0,0,0,0,0, 0,0,0, 1,0,(k-1)/3+1);
    end
    add(0,0,0,1,8,  0,0,0, 0,1,3);
    add(0,0,0,1,9,  0,0,0, 0,1,3);

    // Triggered capture: ten armed cycles, then a rising edge.
    s_trg = tbl.size();
    add(1,0,0,1,'h10, 0,0,0, 1,0,0);
    for (int k = 0; k < 10; k++) add(0,0,0,1,'h20+k, 0,0,0, 1,0,0);
    add(0,0,1,1,'hAA, 0,0,0,  1,0,0);
    add(0,0,1,1,'hBB, 1,50,0, 1,0,1);
    add(0,0,1,1,'hCC, 1,51,1, 1,0,2);
    add(0,0,0,1,'hDD, 0,0,0,  0,1,2);

    // Address wrap at the top of the memory.
    s_wrp = tbl.size();
    add(1,0,0,1,0,     0,0,0,     1,0,0);
    add(0,0,0,1,'h101, 1,16382,0, 1,0,1);
    add(0,0,0,1,'h102, 1,16383,1, 1,0,2);
    add(0,0,0,1,'h103, 1,0,2,     1,0,3);
    add(0,0,0,1,'h104, 1,1,3,     1,0,4);
    add(0,0,0,1,'h105, 0,0,0,     0,1,4);

    // Zero length completes without writing.
    s_zero = tbl.size();
    add(1,0,0,1,5, 0,0,0, 0,1,0);
    add(0,0,0,1,6, 0,0,0, 0,1,0);

    // Abort after two writes, then start+abort together while idle.
    s_abt = tbl.size();
    add(1,0,0,1,0, 0,0,0,   1,0,0);
    add(0,0,0,1,1, 1,200,0, 1,0,1);
    add(0,0,0,1,2, 1,201,1, 1,0,2);
    add(0,1,0,1,3, 0,0,0,   0,0,2);
    add(0,0,0,1,4, 0,0,0,   0,0,2);
    add(1,1,0,1,5, 0,0,0,   0,0,2);
    add(0,0,0,1,6, 0,0,0,   0,0,2);
    s_end = tbl.size();

    repeat (2) @(posedge clk_clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk_clk);
    reset_reset = 1'b0;

    set_cfg(100, 4, 0, 0);      run_rows(s_imm, s_dec);
    set_cfg(0, 3, 2, 0);        run_rows(s_dec, s_trg);
    set_cfg(50, 2, 0, 1);       run_rows(s_trg, s_wrp);
    set_cfg(16382, 4, 0, 0);    run_rows(s_wrp, s_zero);
    set_cfg(7, 0, 0, 0);        run_rows(s_zero, s_abt);
    set_cfg(200, 8, 0, 0);      run_rows(s_abt, s_end);

    // cfg changes after start are ignored; reset drops the write in flight.
    set_cfg(300, 8, 0, 0);
    @(negedge clk_clk);
    start = 1'b1; nco_valid = 1'b1; nco_data = 36'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_clk);
      start = 1'b0;
      set_cfg(999, 2, 5, 1);
      nco_data = 36'(17 + k);
      @(posedge clk_clk);
      #1;
      chk($sformatf("latch w%0d mem_write", k), 64'(mem_bus.mem_write), 64'h1);
      chk($sformatf("latch w%0d address", k), 64'(mem_bus.mem_address), 64'(300 + k));
      chk($sformatf("latch w%0d writedata", k), mem_bus.mem_writedata,
          {13'b0, 15'(k), 36'(17 + k)});
    end
    chk("latch busy", 64'(busy), 64'h1);
    @(negedge clk_clk);
    reset_reset = 1'b1;
    nco_data = 36'h99;
    @(posedge clk_clk);
    #1;
    chk_all_zero("midreset");
    @(negedge clk_clk);
    reset_reset = 1'b0;
    @(posedge clk_clk);
    #1;
    chk("postreset mem_write", 64'(mem_bus.mem_write), 64'h0);
    chk("postreset busy", 64'(busy), 64'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
